// File: rtl/axis_byte_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_byte_packer_if                                             |
// | Brief    : AXI4-Stream bundle (valid/ready/data/keep/last) with modports.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface axis_byte_packer_if #(
   parameter int DATA_WIDTH = 8
);
   localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [KEEP_WIDTH-1:0] keep;
   logic                  last;

   modport master (output valid, data, keep, last, input ready);
   // The byte-side consumer has a single lane, so keep is not part of its view.
   modport slave  (input valid, data, last, output ready);
endinterface
`default_nettype wire

// File: rtl/axis_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_byte_packer                                                |
// | Brief    : Byte-wide to DATA_WIDTH-wide AXI4-Stream upsizer, little-endian.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axis_byte_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic                 clk,
   input  wire logic                 resetn,
   axis_byte_packer_if.slave         s,
   axis_byte_packer_if.master        m,
   output logic [CNT_WIDTH-1:0]      frame_count
);
   localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
   localparam int c_LANE_BITS = $clog2(KEEP_WIDTH);

   logic [c_LANE_BITS-1:0] r_cnt;
   logic [DATA_WIDTH-1:0]  r_acc;
   logic [DATA_WIDTH-1:0]  r_m_data;
   logic [KEEP_WIDTH-1:0]  r_m_keep;
   logic                   r_m_valid;
   logic                   r_m_last;
   logic [CNT_WIDTH-1:0]   r_frame_count;

   logic [DATA_WIDTH-1:0]  w_merged;
   logic [KEEP_WIDTH-1:0]  w_keep;
   logic                   w_s_ready;
   logic                   w_s_fire;
   logic                   w_m_fire;
   logic                   w_complete;

   // Output register is free when empty or draining this cycle.
   assign w_s_ready  = !r_m_valid || m.ready;
   assign w_s_fire   = s.valid && w_s_ready;
   assign w_m_fire   = r_m_valid && m.ready;
   assign w_complete = w_s_fire && ((r_cnt == c_LANE_BITS'(KEEP_WIDTH - 1)) || s.last);

   always_comb begin
      w_merged = r_acc;
      w_keep   = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         if (i == int'(r_cnt)) begin
            w_merged[i*8 +: 8] = s.data;
         end
         w_keep[i] = (i <= int'(r_cnt));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt         <= '0;
         r_acc         <= '0;
         r_m_data      <= '0;
         r_m_keep      <= '0;
         r_m_valid     <= 1'b0;
         r_m_last      <= 1'b0;
         r_frame_count <= '0;
      end else begin
         if (w_s_fire) begin
            if (w_complete) begin
               r_cnt <= '0;
               r_acc <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= w_merged;
            end
         end

         // A completion reloads the output register even while it drains.
         if (w_complete) begin
            r_m_data  <= w_merged;
            r_m_keep  <= w_keep;
            r_m_last  <= s.last;
            r_m_valid <= 1'b1;
         end else if (w_m_fire) begin
            r_m_valid <= 1'b0;
         end

         if (w_m_fire && r_m_last) begin
            r_frame_count <= r_frame_count + 1'b1;
         end
      end
   end

   assign s.ready     = w_s_ready;
   assign m.valid     = r_m_valid;
   assign m.data      = r_m_data;
   assign m.keep      = r_m_keep;
   assign m.last      = r_m_last;
   assign frame_count = r_frame_count;
endmodule
`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_byte_packer                                             |
// | Brief    : Self-checking bench for axis_byte_packer with a queue model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axis_byte_packer;
   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic [CW-1:0] frame_count;

   axis_byte_packer_if #(.DATA_WIDTH(8))  s_if ();
   axis_byte_packer_if #(.DATA_WIDTH(DW)) m_if ();

   axis_byte_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .s           (s_if),
      .m           (m_if),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    tx_data[$];
   logic          tx_last[$];
   logic [7:0]    mdl_cur[$];
   word_t         exp_q[$];
   word_t         obs_q[$];
   logic [CW-1:0] exp_frames;
   int            stall_cycles;
   int            mvalid_cycles;

   // Observe transfers mid-cycle; they complete on the following posedge.
   always @(negedge clk) begin
      if (resetn) begin
         if (m_if.valid && m_if.ready) obs_q.push_back({m_if.data, m_if.keep, m_if.last});
         if (s_if.valid && !s_if.ready) stall_cycles++;
         if (m_if.valid) mvalid_cycles++;
      end
   end

   // Reference: bytes chunk into words of KW, a frame end closes a short word.
   function automatic void add_byte(input logic [7:0] b, input logic l);
      word_t w;
      tx_data.push_back(b);
      tx_last.push_back(l);
      mdl_cur.push_back(b);
      if (mdl_cur.size() == KW || l) begin
         w.data = '0;
         for (int i = 0; i < mdl_cur.size(); i++) w.data = w.data | (DW'(mdl_cur[i]) << (8 * i));
         w.keep = KW'((1 << mdl_cur.size()) - 1);
         w.last = l;
         exp_q.push_back(w);
         mdl_cur.delete();
         if (l) exp_frames = exp_frames + 1'b1;
      end
   endfunction

   task automatic clear_queues();
      tx_data.delete(); tx_last.delete(); mdl_cur.delete();
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0; s_if.valid = 1'b0; m_if.ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      clear_queues();
      exp_frames = '0;
   endtask

   task automatic run_traffic(input int v_pct, input int r_pct, output int timeout, output int iters);
      int budget = 5000;
      iters = 0;
      while (tx_data.size() > 0 && budget > 0) begin
         @(posedge clk); #1;
         s_if.valid = (int'($urandom_range(99)) < v_pct);
         s_if.data  = tx_data[0];
         s_if.last  = tx_last[0];
         m_if.ready = (int'($urandom_range(99)) < r_pct);
         @(negedge clk);
         if (s_if.valid && s_if.ready) begin
            void'(tx_data.pop_front());
            void'(tx_last.pop_front());
         end
         budget--; iters++;
      end
      @(posedge clk); #1;
      s_if.valid = 1'b0; m_if.ready = 1'b1;
      while (obs_q.size() < exp_q.size() && budget > 0) begin
         @(posedge clk); budget--;
      end
      repeat (2) @(posedge clk);
      #1 timeout = (budget == 0) ? 1 : 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (m_if.valid !== 1'b0 || m_if.data !== '0 || m_if.keep !== '0 || m_if.last !== 1'b0 || frame_count !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%b data=%h keep=%h last=%b fc=%0d, expected all zero",
                  m_if.valid, m_if.data, m_if.keep, m_if.last, frame_count);
      end
      n_checks++;
      if (s_if.ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_if.ready);
      end
   endtask

   task automatic test_full_frame();
      int to, it;
      word_t req[2];
      req[0] = {32'h04030201, 4'hF, 1'b0};
      req[1] = {32'h08070605, 4'hF, 1'b1};
      for (int i = 1; i <= 8; i++) add_byte(8'(i), i == 8);
      stall_cycles = 0;
      run_traffic(100, 100, to, it);
      n_checks++;
      if (to != 0 || obs_q.size() != 2) begin
         n_fail++; $display("FAIL full_frame_count: got %0d words (timeout=%0d) expected 2", obs_q.size(), to);
      end
      for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== req[i]) begin
            n_fail++;
            $display("FAIL full_frame_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, req[i].data, req[i].keep, req[i].last);
         end
      end
      n_checks++;
      if (stall_cycles != 0) begin
         n_fail++; $display("FAIL full_frame_s_ready: got %0d stall cycles expected 0", stall_cycles);
      end
      n_checks++;
      if (frame_count !== 16'd1) begin
         n_fail++; $display("FAIL full_frame_fc: got %0d expected 1", frame_count);
      end
   endtask

   task automatic test_partial_tail();
      int to, it;
      word_t req[2];
      req[0] = {32'hA3A2A1A0, 4'hF, 1'b0};
      req[1] = {32'h000000A4, 4'h1, 1'b1};
      clear_queues();
      for (int i = 0; i < 5; i++) add_byte(8'(8'hA0 + i), i == 4);
      run_traffic(100, 100, to, it);
      n_checks++;
      if (to != 0 || obs_q.size() != 2) begin
         n_fail++; $display("FAIL tail_count: got %0d words (timeout=%0d) expected 2", obs_q.size(), to);
      end
      for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== req[i]) begin
            n_fail++;
            $display("FAIL tail_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, req[i].data, req[i].keep, req[i].last);
         end
      end
      n_checks++;
      if (frame_count !== 16'd2) begin
         n_fail++; $display("FAIL tail_fc: got %0d expected 2", frame_count);
      end
   endtask

   task automatic test_single_byte();
      logic [CW-1:0] fc0;
      clear_queues();
      fc0 = frame_count;
      @(posedge clk); #1;
      s_if.valid = 1'b1; s_if.data = 8'h55; s_if.last = 1'b1; m_if.ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_if.ready !== 1'b1 || m_if.valid !== 1'b0) begin
         n_fail++; $display("FAIL single_pre: got s_ready=%b m_valid=%b expected 1/0", s_if.ready, m_if.valid);
      end
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      n_checks++;
      if (m_if.valid !== 1'b1 || m_if.data !== 32'h00000055 || m_if.keep !== 4'h1 || m_if.last !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: got valid=%b data=%h keep=%h last=%b expected 1/00000055/1/1",
                  m_if.valid, m_if.data, m_if.keep, m_if.last);
      end
      m_if.ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (m_if.valid !== 1'b0 || frame_count !== fc0 + 1'b1) begin
         n_fail++; $display("FAIL single_drain: got valid=%b fc=%0d expected 0/%0d", m_if.valid, frame_count, fc0 + 1'b1);
      end
      clear_queues();
   endtask

   task automatic test_backpressure();
      int    to, it;
      logic  ok;
      word_t snap;
      word_t req0;
      req0 = {32'hC3C2C1C0, 4'hF, 1'b0};
      clear_queues();
      for (int i = 0; i < 12; i++) add_byte(8'(8'hC0 + i), i == 11);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         s_if.valid = 1'b1; s_if.data = tx_data[0]; s_if.last = tx_last[0]; m_if.ready = 1'b0;
         @(negedge clk);
         if (s_if.valid && s_if.ready) begin
            void'(tx_data.pop_front()); void'(tx_last.pop_front());
         end
      end
      snap = {m_if.data, m_if.keep, m_if.last};
      n_checks++;
      if (snap !== req0 || m_if.valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_pending: got %h/%h/%b valid=%b expected %h/%h/%b valid=1",
                            snap.data, snap.keep, snap.last, m_if.valid, req0.data, req0.keep, req0.last);
      end
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_if.valid !== 1'b1 || {m_if.data, m_if.keep, m_if.last} !== snap || s_if.ready !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable: got unstable output or s_ready high, expected held word and s_ready=0");
      end
      run_traffic(100, 50, to, it);
      n_checks++;
      if (to != 0 || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL bp_count: got %0d words (timeout=%0d) expected %0d", obs_q.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL bp_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                               obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int to, it;
      clear_queues();
      @(posedge clk); #1;
      s_if.valid = 1'b1; s_if.data = 8'h11; s_if.last = 1'b0; m_if.ready = 1'b1;
      @(posedge clk); #1;
      s_if.data = 8'h22;
      @(posedge clk); #1;
      s_if.valid = 1'b0; resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      n_checks++;
      if (m_if.valid !== 1'b0 || m_if.data !== '0 || m_if.keep !== '0 || m_if.last !== 1'b0 || frame_count !== '0) begin
         n_fail++; $display("FAIL midreset_state: got valid=%b data=%h keep=%h last=%b fc=%0d expected all zero",
                            m_if.valid, m_if.data, m_if.keep, m_if.last, frame_count);
      end
      clear_queues();
      exp_frames = '0;
      add_byte(8'h33, 1'b1);
      run_traffic(100, 100, to, it);
      n_checks++;
      if (to != 0 || obs_q.size() != 1 || obs_q[0] !== {32'h00000033, 4'h1, 1'b1}) begin
         n_fail++; $display("FAIL midreset_next: got %0d words first=%h expected 1 word 00000033/1/1",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 32'h0);
      end
   endtask

   task automatic test_back_to_back();
      int to, it;
      do_reset();
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 4; i++) add_byte(8'($urandom), i == 3);
      stall_cycles  = 0;
      mvalid_cycles = 0;
      run_traffic(100, 100, to, it);
      n_checks++;
      if (to != 0 || it != 12 || stall_cycles != 0) begin
         n_fail++; $display("FAIL b2b_input: got %0d cycles %0d stalls expected 12/0", it, stall_cycles);
      end
      n_checks++;
      if (mvalid_cycles != 3) begin
         n_fail++; $display("FAIL b2b_mvalid: got %0d valid cycles expected 3", mvalid_cycles);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_word%0d: got %0d words, expected %h/%h/%b", i, obs_q.size(),
                               exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      n_checks++;
      if (frame_count !== 16'd3) begin
         n_fail++; $display("FAIL b2b_fc: got %0d expected 3", frame_count);
      end
   endtask

   task automatic test_random();
      int to, it, len;
      clear_queues();
      for (int f = 0; f < 25; f++) begin
         len = int'($urandom_range(1, 10));
         for (int i = 0; i < len; i++) add_byte(8'($urandom), i == len - 1);
      end
      run_traffic(70, 60, to, it);
      n_checks++;
      if (to != 0 || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d words (timeout=%0d) expected %0d", obs_q.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                               obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      n_checks++;
      if (frame_count !== exp_frames) begin
         n_fail++; $display("FAIL rand_fc: got %0d expected %0d", frame_count, exp_frames);
      end
   endtask

   initial begin
      resetn       = 1'b0;
      s_if.valid   = 1'b0;
      s_if.data    = 8'h00;
      s_if.last    = 1'b0;
      s_if.keep    = 1'b1;
      m_if.ready   = 1'b0;
      exp_frames   = '0;
      stall_cycles = 0;
      mvalid_cycles = 0;
      test_reset();
      test_full_frame();
      test_partial_tail();
      test_single_byte();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
